// File: rtl/knn_voter_pkg.sv
// Shared constants, derived widths and FSM encoding for the k-NN voter.
// The sorter and the software register map use the same values.
package knn_voter_pkg;

   localparam int K       = 4;
   localparam int IDX_W   = 8;
   localparam int LABEL_W = 4;
   localparam int NCLASS  = 10;
   localparam int SEL_W   = $clog2(K);
   localparam int VOTE_W  = $clog2(K + 1);
   localparam int RANK_W  = SEL_W + 1;

   // A first-rank value of K means "class not seen yet".
   localparam logic [RANK_W-1:0]  RANK_NONE  = RANK_W'(K);
   localparam logic [SEL_W-1:0]   LAST_RANK  = SEL_W'(K - 1);
   localparam logic [LABEL_W-1:0] LAST_CLASS = LABEL_W'(NCLASS - 1);
   localparam logic [LABEL_W-1:0] NCLASS_L   = LABEL_W'(NCLASS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DECIDE,
      ST_DONE
   } voter_state_e;

   function automatic logic isValidLabel(input logic [LABEL_W-1:0] label);
      return label < NCLASS_L;
   endfunction

endpackage

// File: rtl/knn_voter_label.sv
// Label memory: one write port, one synchronous read port, contents
// survive reset so software only has to load training labels once.
module knn_label_mem
   import knn_voter_pkg::*;
(
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   waddr_i,
   input  logic [LABEL_W-1:0] wdata_i,
   input  logic               re_i,
   input  logic [IDX_W-1:0]   raddr_i,
   output logic [LABEL_W-1:0] rdata_o
);

   logic [LABEL_W-1:0] mem [2**IDX_W];
   logic [LABEL_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/knn_voter.sv
// Walks the K nearest ranks from the sorter, tallies one vote per valid
// label and picks the majority class, breaking ties by nearest member.
module knn_voter
   import knn_voter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               lbl_we,
   input  logic [IDX_W-1:0]   lbl_waddr,
   input  logic [LABEL_W-1:0] lbl_wdata,
   output logic [SEL_W-1:0]   sel,
   input  logic [IDX_W-1:0]   idx_in,
   output logic               busy,
   output logic               done,
   output logic [LABEL_W-1:0] class_out,
   output logic [VOTE_W-1:0]  class_votes
);

   voter_state_e state_q, state_d;
   logic [SEL_W-1:0]                ptr_q, ptr_d;
   logic [LABEL_W-1:0]              cls_q, cls_d;
   logic [NCLASS-1:0][VOTE_W-1:0]   count_q, count_d;
   logic [NCLASS-1:0][RANK_W-1:0]   first_q, first_d;
   logic [LABEL_W-1:0]              bestCls_q, bestCls_d;
   logic [VOTE_W-1:0]               bestCnt_q, bestCnt_d;
   logic [RANK_W-1:0]               bestRank_q, bestRank_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic [LABEL_W-1:0]              class_q, class_d;
   logic [VOTE_W-1:0]               votes_q, votes_d;

   logic [LABEL_W-1:0] memLabel;
   logic               tallyEn;
   logic [SEL_W-1:0]   tallyRank;
   logic [VOTE_W-1:0]  candCnt;
   logic [RANK_W-1:0]  candRank;

   // Writes only land in IDLE, so they never race a lookup.
   knn_label_mem u_label_mem (
      .clk_i   (clk),
      .we_i    (lbl_we && (state_q == ST_IDLE)),
      .waddr_i (lbl_waddr),
      .wdata_i (lbl_wdata),
      .re_i    (state_q == ST_FETCH),
      .raddr_i (idx_in),
      .rdata_o (memLabel)
   );

   assign sel         = (state_q == ST_FETCH) ? ptr_q : '0;
   assign busy        = busy_q;
   assign done        = done_q;
   assign class_out   = class_q;
   assign class_votes = votes_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cls_q      <= '0;
         count_q    <= '0;
         first_q    <= '0;
         bestCls_q  <= '0;
         bestCnt_q  <= '0;
         bestRank_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         class_q    <= '0;
         votes_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cls_q      <= cls_d;
         count_q    <= count_d;
         first_q    <= first_d;
         bestCls_q  <= bestCls_d;
         bestCnt_q  <= bestCnt_d;
         bestRank_q <= bestRank_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         class_q    <= class_d;
         votes_q    <= votes_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cls_d      = cls_q;
      count_d    = count_q;
      first_d    = first_q;
      bestCls_d  = bestCls_q;
      bestCnt_d  = bestCnt_q;
      bestRank_d = bestRank_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      class_d    = class_q;
      votes_d    = votes_q;

      // The memory read lags by one cycle, so the label arriving now
      // belongs to the rank selected on the previous cycle.
      tallyEn   = ((state_q == ST_FETCH) && (ptr_q != '0)) || (state_q == ST_DRAIN);
      tallyRank = (state_q == ST_DRAIN) ? LAST_RANK : ptr_q - 1'b1;
      if (tallyEn && isValidLabel(memLabel)) begin
         count_d[memLabel] = count_q[memLabel] + 1'b1;
         if (first_q[memLabel] == RANK_NONE) begin
            first_d[memLabel] = {1'b0, tallyRank};
         end
      end

      candCnt  = count_q[cls_q];
      candRank = first_q[cls_q];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d = '0;
               for (int c = 0; c < NCLASS; c++) begin
                  first_d[c] = RANK_NONE;
               end
               ptr_d   = '0;
               busy_d  = 1'b1;
               class_d = '0;
               votes_d = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (ptr_q == LAST_RANK) begin
               state_d = ST_DRAIN;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            cls_d      = '0;
            bestCls_d  = '0;
            bestCnt_d  = '0;
            bestRank_d = RANK_NONE;
            state_d    = ST_DECIDE;
         end
         ST_DECIDE: begin
            if ((candCnt > bestCnt_q) ||
                ((candCnt == bestCnt_q) && (candCnt != '0) && (candRank < bestRank_q))) begin
               bestCls_d  = cls_q;
               bestCnt_d  = candCnt;
               bestRank_d = candRank;
            end
            if (cls_q == LAST_CLASS) begin
               state_d = ST_DONE;
            end else begin
               cls_d = cls_q + 1'b1;
            end
         end
         ST_DONE: begin
            class_d = bestCls_q;
            votes_d = bestCnt_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_knn_voter.sv
// Self-checking bench for knn_voter: table vectors, control corner cases
// and random votes compared against a counting reference model.
module tb_knn_voter;
   import knn_voter_pkg::*;

   typedef struct {
      string           name;
      logic [3:0][7:0] idx;
      logic [3:0][3:0] lbl;
      int              expClass;
      int              expVotes;
   } vector_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       lbl_we;
   logic [7:0] lbl_waddr;
   logic [3:0] lbl_wdata;
   logic [1:0] sel;
   logic [7:0] idx_in;
   logic       busy;
   logic       done;
   logic [3:0] class_out;
   logic [2:0] class_votes;

   logic [3:0][7:0] rankIdx;
   int              lblModel [256];
   int              nCompared = 0;
   int              nMismatched = 0;
   vector_t         vec [5];

   knn_voter dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .lbl_we      (lbl_we),
      .lbl_waddr   (lbl_waddr),
      .lbl_wdata   (lbl_wdata),
      .sel         (sel),
      .idx_in      (idx_in),
      .busy        (busy),
      .done        (done),
      .class_out   (class_out),
      .class_votes (class_votes)
   );

   // Sorter stand-in: returns the index held at the selected rank.
   assign idx_in = rankIdx[sel];

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [3:0][7:0] packIdx(input int r0, input int r1, input int r2, input int r3);
      logic [3:0][7:0] p;
      p[0] = 8'(r0); p[1] = 8'(r1); p[2] = 8'(r2); p[3] = 8'(r3);
      return p;
   endfunction

   function automatic logic [3:0][3:0] packLbl(input int r0, input int r1, input int r2, input int r3);
      logic [3:0][3:0] p;
      p[0] = 4'(r0); p[1] = 4'(r1); p[2] = 4'(r2); p[3] = 4'(r3);
      return p;
   endfunction

   // Majority of valid labels; among tied classes the one seen at the
   // nearest rank wins; no valid labels gives class 0 with 0 votes.
   function automatic void refVote(input logic [3:0][7:0] idxs, output int cls, output int votes);
      int counts [16];
      int firstSeen [16];
      int maxCount;
      int bestFirst;
      foreach (counts[c]) begin
         counts[c] = 0;
         firstSeen[c] = 99;
      end
      for (int r = 0; r < 4; r++) begin
         int l;
         l = lblModel[idxs[r]];
         if (l < 10) begin
            counts[l]++;
            if (firstSeen[l] == 99) firstSeen[l] = r;
         end
      end
      maxCount = 0;
      foreach (counts[c]) if (counts[c] > maxCount) maxCount = counts[c];
      cls = 0;
      votes = maxCount;
      bestFirst = 99;
      if (maxCount > 0) begin
         foreach (counts[c]) begin
            if (counts[c] == maxCount && firstSeen[c] < bestFirst) begin
               bestFirst = firstSeen[c];
               cls = c;
            end
         end
      end
   endfunction

   task automatic writeLabel(input int idx, input int lbl);
      lbl_we    = 1'b1;
      lbl_waddr = 8'(idx);
      lbl_wdata = 4'(lbl);
      tick();
      lbl_we = 1'b0;
      lblModel[idx] = lbl;
   endtask

   // Pulses start, optionally injects stray starts / a busy-time write,
   // then waits (bounded) for done and optionally watches extra cycles.
   task automatic applyStimulus(input logic [3:0][7:0] idxs, input int extraA, input int extraB,
                                input int busyWriteAt, input int tailCycles,
                                output int gotClass, output int gotVotes, output int latency,
                                output int doneCount, output int busyAtDone);
      rankIdx = idxs;
      gotClass = -1;
      gotVotes = -1;
      latency = -1;
      doneCount = 0;
      busyAtDone = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         start = (n == extraA) || (n == extraB);
         if (n == busyWriteAt) begin
            lbl_we    = 1'b1;
            lbl_waddr = idxs[0];
            lbl_wdata = 4'(lblModel[idxs[0]] ^ 4);
         end
         tick();
         start  = 1'b0;
         lbl_we = 1'b0;
         if (done) begin
            latency = n;
            doneCount = 1;
            gotClass = int'(class_out);
            gotVotes = int'(class_votes);
            busyAtDone = int'(busy);
            break;
         end
      end
      for (int t = 0; t < tailCycles; t++) begin
         tick();
         if (done) doneCount++;
      end
   endtask

   task automatic runAndCheck(input string name, input logic [3:0][7:0] idxs, input int extraA,
                              input int extraB, input int busyWriteAt, input int tailCycles,
                              input int expClass, input int expVotes);
      int gotClass, gotVotes, latency, doneCount, busyAtDone;
      applyStimulus(idxs, extraA, extraB, busyWriteAt, tailCycles,
                    gotClass, gotVotes, latency, doneCount, busyAtDone);
      checkOutput($sformatf("%s.latency", name), latency, 16);
      checkOutput($sformatf("%s.class", name), gotClass, expClass);
      checkOutput($sformatf("%s.votes", name), gotVotes, expVotes);
      checkOutput($sformatf("%s.busyAtDone", name), busyAtDone, 0);
      if (tailCycles > 0) checkOutput($sformatf("%s.doneCount", name), doneCount, 1);
   endtask

   initial begin
      int mCls, mVotes;
      int doneSeen;
      logic [3:0][7:0] rIdx;

      vec[0] = '{"majority", packIdx(12, 40, 7, 99), packLbl(3, 3, 7, 1), 3, 2};
      vec[1] = '{"tieBreak", packIdx(20, 21, 22, 23), packLbl(5, 2, 2, 5), 5, 2};
      vec[2] = '{"distinct", packIdx(30, 31, 32, 33), packLbl(8, 1, 4, 6), 8, 1};
      vec[3] = '{"invalid",  packIdx(50, 51, 52, 53), packLbl(12, 15, 4, 13), 4, 1};
      vec[4] = '{"allInval", packIdx(60, 61, 62, 63), packLbl(10, 11, 14, 15), 0, 0};

      rst = 1'b1;
      start = 1'b0;
      lbl_we = 1'b0;
      lbl_waddr = '0;
      lbl_wdata = '0;
      rankIdx = '0;
      foreach (lblModel[i]) lblModel[i] = 0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset.sel", int'(sel), 0);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.done", int'(done), 0);
      checkOutput("reset.class", int'(class_out), 0);
      checkOutput("reset.votes", int'(class_votes), 0);

      for (int v = 0; v < 5; v++) begin
         for (int r = 0; r < 4; r++) writeLabel(int'(vec[v].idx[r]), int'(vec[v].lbl[r]));
         runAndCheck(vec[v].name, vec[v].idx, 0, 0, 0, 0, vec[v].expClass, vec[v].expVotes);
      end

      runAndCheck("strayStart", vec[0].idx, 3, 10, 0, 20, 3, 2);
      runAndCheck("busyWrite", vec[0].idx, 0, 0, 5, 0, 3, 2);
      runAndCheck("readback", vec[0].idx, 0, 0, 0, 0, 3, 2);

      runAndCheck("backToBackA", vec[2].idx, 0, 0, 0, 0, 8, 1);
      runAndCheck("backToBackB", vec[1].idx, 0, 0, 0, 0, 5, 2);

      rankIdx = vec[1].idx;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midReset.busy", int'(busy), 0);
      checkOutput("midReset.done", int'(done), 0);
      checkOutput("midReset.class", int'(class_out), 0);
      checkOutput("midReset.votes", int'(class_votes), 0);
      doneSeen = 0;
      repeat (20) begin
         tick();
         if (done) doneSeen++;
      end
      checkOutput("midReset.noDone", doneSeen, 0);
      refVote(vec[0].idx, mCls, mVotes);
      runAndCheck("afterReset", vec[0].idx, 0, 0, 0, 0, mCls, mVotes);

      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < 4; r++) begin
            rIdx[r] = 8'(100 + $urandom_range(0, 59));
            writeLabel(int'(rIdx[r]), int'($urandom_range(0, 12)));
         end
         refVote(rIdx, mCls, mVotes);
         runAndCheck($sformatf("random%0d", it), rIdx, 0, 0, 0, 0, mCls, mVotes);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/knn_voter.md
Name: knn_voter

Overview:
- Downstream stage of the k-NN insertion sorter. After the sorter has ranked all distances, this block walks the K nearest-neighbour indices through the sorter's rank-select port.
- Each index is looked up in an on-chip label memory and counted as one vote for its class.
- The block outputs the majority class to the software-visible register bank.
- Label memory is loaded by software before classification.

Parameters:
- K, 4, number of neighbours voted; must match sorter depth.
- IDX_W, 8, width of a training-point index (sorter index width).
- LABEL_W, 4, width of a class label.
- NCLASS, 10, number of valid classes; labels >= NCLASS are invalid.
- SEL_W, 2, width of rank select; equals $clog2(K).
- VOTE_W, 3, width of vote count; equals $clog2(K+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begin a vote
- lbl_we  in  1  label memory write enable
- lbl_waddr  in  IDX_W  label memory write address (training index)
- lbl_wdata  in  LABEL_W  label to store
- sel  out  SEL_W  rank select driven to the sorter (0 = nearest)
- idx_in  in  IDX_W  index returned by the sorter for `sel`; combinational, same cycle
- busy  out  1  high from the cycle after start is accepted until done; software holds the sorter's ready low while busy
- done  out  1  one-cycle pulse; result valid
- class_out  out  LABEL_W  winning class; held until the next accepted start or rst
- class_votes  out  VOTE_W  vote count of the winning class; held with class_out

Behaviour:
- Reset: on rst high at a clock edge, all outputs and state are set as follows:
  - FSM goes to IDLE.
  - sel=0, busy=0, done=0, class_out=0, class_votes=0.
  - Vote counters and first-rank registers are cleared.
  - Label memory is not cleared.
  - rst overrides everything, including mid-operation; the in-flight vote is discarded.
- FSM states are IDLE, FETCH, DRAIN, DECIDE, DONE.
- IDLE:
  - start=1 clears all NCLASS vote counters, sets first_rank[c]=K for every class, sets ptr=0, and moves to FETCH.
  - start in any other state is ignored.
- FETCH:
  - sel=ptr; the label memory read address is idx_in.
  - The label memory has a synchronous read with 1-cycle latency.
  - The label returned for rank ptr-1 is counted in the same cycle. When it is valid (< NCLASS):
    - count[label]++;
    - if first_rank[label]==K, then first_rank[label]=ptr-1.
  - After ptr==K-1, move to DRAIN.
- DRAIN: counts the label for rank K-1, sets cls=0 and best=none, then moves to DECIDE.
- DECIDE: evaluates one class per cycle, cls=0..NCLASS-1. Class cls replaces best if either:
  - count[cls] > best_cnt; or
  - count[cls] == best_cnt, count>0, and first_rank[cls] < best_rank.
  - The tie-break therefore favours the class whose nearest member ranks closest.
  - After cls==NCLASS-1, move to DONE.
- DONE:
  - Register class_out and class_votes, pulse done=1, and return to IDLE.
  - If no valid votes were cast, class_out=0 and class_votes=0.
- Latency: done is high exactly K+NCLASS+2 cycles after the edge that samples start. With the defaults this is 16.
- Back-to-back: a start in the cycle immediately after done is accepted.
- Label writes:
  - lbl_we is honoured only in IDLE and ignored otherwise, so a lookup and a write never collide.
  - A write and a start in the same IDLE cycle: the write takes effect and the start is accepted.
- Vote counters are VOTE_W wide and cannot overflow, since there are at most K votes.

Decomposition:
- Shared header knn.vh holds:
  - constants K, IDX_W, LABEL_W, NCLASS;
  - FSM state encodings;
  - derived widths.
- This header is shared with the sorter and the software register map.
- One sub-module, knn_label_mem: 2^IDX_W x LABEL_W register array, one write port, one synchronous read port, no reset.
- The FSM, counters and arbitration stay in knn_voter.

Test Plan:
- Majority: labels of idx {12,40,7,99} = {3,3,7,1}, start -> done at cycle 16, class_out=3, class_votes=2.
- Tie-break: labels by rank {5,2,2,5} -> class_out=5, votes=2 (rank-0 class wins). All-distinct {8,1,4,6} -> class_out=8, votes=1.
- Invalid labels: ranks {12,15,4,13} (three ≥ NCLASS) -> class_out=4, votes=1. All invalid -> class_out=0, votes=0, and done still pulses at cycle 16.
- Control robustness:
  - start asserted again at cycles 3 and 10 of a run -> ignored, exactly one done pulse.
  - lbl_we during busy -> memory unchanged, checked by a readback vote.
  - start the cycle after done -> second result at +16.
- Reset mid-operation: rst at cycle 8 -> next cycle busy=0, done=0, class_out=0, class_votes=0. Labels are retained, and a fresh start yields the correct class.
